cache_line_xfer: RTL
====================

// Module: cache_line_xfer
// PURPOSE
//  Burst engine between a cache controller and one slave port of the bus arbiter.
//  Moves one cache line per request over pipelined Wishbone (if_wb master side):
//  a line fill reads LINE_WORDS words into the line RAM; an eviction writes them from it.
//  Owns a single cycle (cyc) for the whole burst so the arbiter cannot interleave it.
// PARAMETERS
//  LINE_WORDS  4    words per line; power of 2, >=2
//  TIMEOUT     255  max cycles with cyc=1 and no ack before abort; must be >=1
// PORTS
//  clk_i       in   1        clock
//  rst_i       in   1        asynchronous, active-high reset
//  req_i       in   1        start transfer; sampled only in IDLE
//  we_i        in   1        0=fill (bus read), 1=evict (bus write); latched with req_i
//  line_adr_i  in   32-LW-2  line address (LW=$clog2(LINE_WORDS)); latched with req_i
//  busy_o      out  1        high from the cycle after acceptance through DONE
//  done_o      out  1        one-cycle completion pulse
//  err_o       out  1        valid with done_o; 1 = timeout abort
//  ram_wr_o    out  1        fill: write strobe to line RAM
//  ram_wr_idx_o out LW       fill: word index
//  ram_wr_dat_o out 32       fill: word data
//  ram_rd_idx_o out LW       evict: read index to sync line RAM (1-cycle latency)
//  ram_rd_dat_i in  32       evict: RAM data for the index presented last cycle
//  bus         if_wb.master  cyc, stb, adr, we, sel, dat_o out; ack, stall, dat_i in
// BEHAVIOUR
//  Reset values: all outputs 0; cyc/stb/we/adr/sel=0; state IDLE; counters 0.
//  Reset mid-burst drops cyc/stb at once (async); no done_o is produced.
//  States: IDLE -> (req_i & we_i) PREP -> ISSUE; IDLE -> (req_i & !we_i) ISSUE;
//   ISSUE -> WAIT once all LINE_WORDS are accepted (stb & !stall);
//   WAIT -> DONE once the ack count reaches LINE_WORDS; any state with cyc -> DONE on timeout.
//   DONE -> IDLE after exactly one cycle. req_i outside IDLE is ignored.
//  PREP (evict only): cyc=0; ram_rd_idx_o=0 to prefetch word 0.
//  ISSUE: cyc=1, stb=1, sel=4'hF, we=latched we_i.
//   adr={line_adr, issue_cnt, 2'b00}; issue_cnt increments on stb & !stall.
//   Stall holds adr, dat_o and issue_cnt.
//  Evict data: ram_rd_idx_o = issue_cnt + (stb & !stall), combinational from registered state.
//   bus.dat_o = ram_rd_dat_i while stb & we, else 0.
//  Pipelining: a new word may be issued every cycle; acks may lag and may arrive in the
//   same cycle a word is issued. Slaves ack in order.
//  cyc stays 1 from the first ISSUE cycle until the cycle after the last ack, then drops.
//   stb is 0 in WAIT.
//  Fill write-back is registered: the cycle after the k-th ack (k=0..LW-1),
//   ram_wr_o=1, ram_wr_idx_o=k, ram_wr_dat_o=captured bus.dat_i.
//  Extra acks after LINE_WORDS are ignored; ack with cyc=0 is ignored.
//  Timeout: tmo_cnt clears on every ack and at the start of each burst, else increments
//   while cyc. On reaching TIMEOUT: cyc/stb drop next cycle, DONE with err_o=1.
//   Partial fill writes already issued remain; no retry.
//  done_o=1 only in DONE. err_o=0 except with a timeout done_o. busy_o=1 in PREP/ISSUE/WAIT/DONE.
//  Counters are LW+1 bits wide so the terminal count LINE_WORDS is representable.
//   issue_cnt's low LW bits form the adr word field.
// STRUCTURE
//  cache_pkg: xfer_state_t enum (IDLE, PREP, ISSUE, WAIT, DONE).
//   Also holds LINE_WORDS_DEF=4, WB_SEL_ALL=4'hF and function idx_w(n)=$clog2(n).
//  Single module, no sub-module: two counters, tmo counter, FSM, fill capture register.
// TESTING
//  1 Fill, LINE_WORDS=4, line_adr=0x100, slave acks 1 cycle after each stb, no stall:
//    adr 0x1000,0x1004,0x1008,0x100C on consecutive cycles; ram writes idx0..3 with
//    slave data; done_o 1 cycle; err_o=0.
//  2 Evict of line 0x20, RAM word k=0xA0+k, slave stalls the 2nd word 3 cycles:
//    dat_o/adr held during stall; slave sees 0xA0..0xA3 at 0x200..0x20C in order.
//  3 Acks delayed 4 cycles behind issue (4 outstanding):
//    cyc continuous; cyc drops the cycle after 4th ack; exactly 4 ram writes.
//  4 TIMEOUT=8, slave never acks: cyc drops after 8 ack-less cycles;
//    done_o=1 and err_o=1 together; busy_o returns 0.
//  5 req_i held high through a burst and after: exactly one transfer per IDLE entry;
//    req_i during ISSUE ignored; new burst starts the cycle after DONE->IDLE.
//  6 rst_i asserted mid-ISSUE: cyc/stb/busy_o low immediately; no done_o;
//    a fresh fill after release completes correctly.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache line transfer engine.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ISSUE,
    WAIT,
    DONE
  } xfer_state_t;

  localparam int         LINE_WORDS_DEF = 4;
  localparam logic [3:0] WB_SEL_ALL     = 4'hF;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bundle; dat_o/dat_i named from the master's side.
interface if_wb;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_o,
    input  ack, stall, dat_i
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_o,
    output ack, stall, dat_i
  );

endinterface

// File: rtl/cache_line_xfer.sv
// Cache line burst engine: one Wishbone cycle per line fill or eviction.
module cache_line_xfer
  import cache_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int TIMEOUT    = 255,
  localparam int LW = idx_w(LINE_WORDS),
  localparam int CW = LW + 1,
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req_i,
  input  logic           we_i,
  input  logic [29-LW:0] line_adr_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o,
  output logic           ram_wr_o,
  output logic [LW-1:0]  ram_wr_idx_o,
  output logic [31:0]    ram_wr_dat_o,
  output logic [LW-1:0]  ram_rd_idx_o,
  input  logic [31:0]    ram_rd_dat_i,
  if_wb.master           bus
);

  xfer_state_t state_q, state_d;

  logic           we_q, we_d;
  logic [29-LW:0] line_q, line_d;
  logic [CW-1:0]  iss_q, iss_d;
  logic [CW-1:0]  ack_q, ack_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           cyc_q, cyc_d;
  logic           stb_q, stb_d;
  logic           err_q, err_d;
  logic           wr_q, wr_d;
  logic [LW-1:0]  wr_idx_q, wr_idx_d;
  logic [31:0]    wr_dat_q, wr_dat_d;

  logic take;
  logic ack_ok;

  assign take   = stb_q & ~bus.stall;
  // Acks beyond the line or outside a cycle are dropped here.
  assign ack_ok = cyc_q & bus.ack & (ack_q != CW'(LINE_WORDS));

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    line_d   = line_q;
    iss_d    = iss_q;
    ack_d    = ack_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    wr_d     = 1'b0;
    wr_idx_d = wr_idx_q;
    wr_dat_d = wr_dat_q;

    if (take) begin
      iss_d = iss_q + CW'(1);
    end
    if (ack_ok) begin
      ack_d    = ack_q + CW'(1);
      wr_d     = ~we_q;
      wr_idx_d = ack_q[LW-1:0];
      wr_dat_d = bus.dat_i;
    end
    if (cyc_q) begin
      tmo_d = ack_ok ? '0 : tmo_q + TW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          line_d  = line_adr_i;
          iss_d   = '0;
          ack_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
          state_d = we_i ? PREP : ISSUE;
        end
      end
      PREP: begin
        state_d = ISSUE;
      end
      ISSUE, WAIT: begin
        if (ack_d == CW'(LINE_WORDS)) begin
          state_d = DONE;
        end else if (tmo_d == TW'(TIMEOUT)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (state_q == ISSUE && iss_d == CW'(LINE_WORDS)) begin
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cyc_d = (state_d == ISSUE) | (state_d == WAIT);
    stb_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      line_q   <= '0;
      iss_q    <= '0;
      ack_q    <= '0;
      tmo_q    <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      wr_idx_q <= '0;
      wr_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      line_q   <= line_d;
      iss_q    <= iss_d;
      ack_q    <= ack_d;
      tmo_q    <= tmo_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      wr_idx_q <= wr_idx_d;
      wr_dat_q <= wr_dat_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign err_o        = (state_q == DONE) & err_q;
  assign ram_wr_o     = wr_q;
  assign ram_wr_idx_o = wr_idx_q;
  assign ram_wr_dat_o = wr_dat_q;

  // Look one word ahead on acceptance so the sync RAM keeps pace.
  assign ram_rd_idx_o = iss_q[LW-1:0] + LW'(take);

  assign bus.cyc   = cyc_q;
  assign bus.stb   = stb_q;
  assign bus.we    = cyc_q & we_q;
  assign bus.sel   = stb_q ? WB_SEL_ALL : 4'h0;
  assign bus.adr   = stb_q ? {line_q, iss_q[LW-1:0], 2'b00} : 32'h0;
  assign bus.dat_o = (stb_q & we_q) ? ram_rd_dat_i : 32'h0;

endmodule
